// File: rtl/err_injector.sv
// err_injector: per-frame channel-error injector for a beat stream.
// Error positions are drawn in the DRAW state. The LFSR steps only in DRAW, so
// a given seed and configuration always give the same pattern, whatever
// backpressure the downstream applies. The RUN state streams one frame through
// a single output register and flips the drawn bits on the way.
//
// Handshake (valid/ready): a beat moves on a port in a cycle where both valid
// and ready are high at the clock edge. valid_out, once raised, stays high and
// data_out/err_out/sof_out/eof_out stay stable until ready_out takes the beat.
// The upstream side sees ready_in only in RUN, and only when the output
// register is empty or is being drained in that same cycle.
module err_injector #(
    parameter int          DATA_W    = 1,
    parameter int          FRAME_LEN = 63,
    parameter int          MAX_ERR   = 2,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
    parameter int          CNT_W     = 16,
    localparam int         NUM_W     = $clog2(MAX_ERR + 1),
    localparam int         IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic [NUM_W-1:0]  cfg_num_err,
    input  logic [IDX_W-1:0]  cfg_fixed_pos,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic              err_out,
    output logic              sof_out,
    output logic              eof_out,
    output logic [CNT_W-1:0]  err_total,
    output logic [CNT_W-1:0]  frame_total,
    output logic              dbg_state
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int EW    = IDX_W + NUM_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
    localparam logic [EW-1:0]    LAST_EW     = EW'(FRAME_LEN - 1);
    localparam logic [IDX_W:0]   FRAME_LEN_C = (IDX_W + 1)'(FRAME_LEN);
    localparam logic [BIT_W:0]   DATA_W_C    = (BIT_W + 1)'(DATA_W);
    localparam logic [NUM_W-1:0] MAX_ERR_C   = NUM_W'(MAX_ERR);
    localparam logic [31:0]      LFSR_TAPS   = 32'h8020_0003;

    localparam logic [1:0] MODE_RANDOM = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;
    localparam logic [1:0] MODE_FIXED  = 2'b11;

    typedef enum logic {ST_DRAW = 1'b0, ST_RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_next;
    logic [IDX_W-1:0]   idx_q;
    logic               cfg_load_q;
    logic [1:0]         mode_q, mode_e;
    logic [NUM_W-1:0]   n_q, n_raw, n_e, acc_q;
    logic [IDX_W-1:0]   slot_beat_q [MAX_ERR];
    logic [BIT_W-1:0]   slot_bit_q  [MAX_ERR];
    logic               burst_en_q;
    logic [IDX_W-1:0]   burst_lo_q, burst_hi_q;
    logic [BIT_W-1:0]   burst_bit_q;

    logic [IDX_W-1:0]   cand_beat;
    logic [BIT_W-1:0]   cand_bit;
    logic               cand_ok, cand_dup;
    logic               take_slot, take_burst;
    logic [IDX_W-1:0]   burst_lo_d, burst_hi_d;
    logic [BIT_W-1:0]   burst_bit_d;
    logic [EW-1:0]      end_sum;
    logic [DATA_W-1:0]  mask;
    logic               in_fire, last_beat;

    // Galois right-shift step, polynomial x^32 + x^22 + x^2 + x + 1.
    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    assign cand_beat = lfsr_q[IDX_W-1:0];
    if (DATA_W > 1) begin : g_bit_draw
        assign cand_bit = lfsr_q[IDX_W +: BIT_W];
    end else begin : g_bit_zero
        assign cand_bit = '0;
    end
    assign cand_ok = ({1'b0, cand_beat} < FRAME_LEN_C) && ({1'b0, cand_bit} < DATA_W_C);

    // The config is live on the first DRAW cycle and latched for the rest of the frame.
    assign mode_e = cfg_load_q ? cfg_mode : mode_q;
    assign n_raw  = cfg_load_q ? cfg_num_err : n_q;
    assign n_e    = (n_raw > MAX_ERR_C) ? MAX_ERR_C : n_raw;

    assign ready_in  = (state_q == ST_RUN) && (ready_out || !valid_out);
    assign in_fire   = valid_in && ready_in;
    assign last_beat = (idx_q == LAST_IDX);
    assign dbg_state = (state_q == ST_RUN);

    // Next state and the position draw for the current DRAW cycle.
    always_comb begin
        state_d     = state_q;
        take_slot   = 1'b0;
        take_burst  = 1'b0;
        burst_lo_d  = cand_beat;
        burst_bit_d = cand_bit;
        cand_dup    = 1'b0;
        for (int k = 0; k < MAX_ERR; k++) begin
            if ((NUM_W'(k) < acc_q) && (slot_beat_q[k] == cand_beat)) cand_dup = 1'b1;
        end
        case (state_q)
            ST_DRAW: begin
                case (mode_e)
                    MODE_RANDOM: begin
                        if (n_e == '0) begin
                            state_d = ST_RUN;
                        end else if (cand_ok && !cand_dup) begin
                            take_slot = 1'b1;
                            if (acc_q + 1'b1 == n_e) state_d = ST_RUN;
                        end
                    end
                    MODE_BURST: begin
                        if (n_e == '0) begin
                            state_d = ST_RUN;
                        end else if (cand_ok) begin
                            take_burst = 1'b1;
                            state_d    = ST_RUN;
                        end
                    end
                    MODE_FIXED: begin
                        burst_lo_d  = cfg_fixed_pos;
                        burst_bit_d = '0;
                        take_burst  = (n_e != '0);
                        state_d     = ST_RUN;
                    end
                    default: state_d = ST_RUN;
                endcase
            end
            default: begin
                if (in_fire && last_beat) state_d = ST_DRAW;
            end
        endcase
        // A burst stops at the last beat of the frame instead of wrapping round.
        end_sum    = EW'(burst_lo_d) + EW'(n_e) - EW'(1);
        burst_hi_d = (end_sum > LAST_EW) ? LAST_IDX : end_sum[IDX_W-1:0];
    end

    // Flip mask for the beat at idx_q, built from the drawn slots and burst range.
    always_comb begin
        mask = '0;
        for (int k = 0; k < MAX_ERR; k++) begin
            if ((NUM_W'(k) < acc_q) && (slot_beat_q[k] == idx_q))
                mask = mask | (DATA_W'(1) << slot_bit_q[k]);
        end
        if (burst_en_q && (idx_q >= burst_lo_q) && (idx_q <= burst_hi_q))
            mask = mask | (DATA_W'(1) << burst_bit_q);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_DRAW;
        else     state_q <= state_d;
    end

    // LFSR, latched config and drawn error positions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q      <= LFSR_SEED;
            cfg_load_q  <= 1'b1;
            mode_q      <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            burst_en_q  <= 1'b0;
            burst_lo_q  <= '0;
            burst_hi_q  <= '0;
            burst_bit_q <= '0;
            for (int k = 0; k < MAX_ERR; k++) begin
                slot_beat_q[k] <= '0;
                slot_bit_q[k]  <= '0;
            end
        end else if (state_q == ST_DRAW) begin
            lfsr_q <= lfsr_next;
            if (cfg_load_q) begin
                cfg_load_q <= 1'b0;
                mode_q     <= cfg_mode;
                n_q        <= n_e;
            end
            if (take_slot) begin
                for (int k = 0; k < MAX_ERR; k++) begin
                    if (acc_q == NUM_W'(k)) begin
                        slot_beat_q[k] <= cand_beat;
                        slot_bit_q[k]  <= cand_bit;
                    end
                end
                acc_q <= acc_q + 1'b1;
            end
            if (take_burst) begin
                burst_en_q  <= 1'b1;
                burst_lo_q  <= burst_lo_d;
                burst_hi_q  <= burst_hi_d;
                burst_bit_q <= burst_bit_d;
            end
        end else if (in_fire && last_beat) begin
            cfg_load_q <= 1'b1;
            acc_q      <= '0;
            burst_en_q <= 1'b0;
        end
    end

    // Output register stage and beat index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            err_out   <= 1'b0;
            sof_out   <= 1'b0;
            eof_out   <= 1'b0;
        end else if (in_fire) begin
            idx_q     <= last_beat ? '0 : idx_q + 1'b1;
            valid_out <= 1'b1;
            data_out  <= data_in ^ mask;
            err_out   <= |mask;
            sof_out   <= (idx_q == '0);
            eof_out   <= last_beat;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_total   <= '0;
            frame_total <= '0;
        end else if (in_fire) begin
            if ((|mask) && (err_total != '1)) err_total <= err_total + 1'b1;
            if (last_beat && (frame_total != '1)) frame_total <= frame_total + 1'b1;
        end
    end

endmodule

// File: tb/tb_err_injector.sv
// tb_err_injector: directed bench for err_injector.
// Instance a is 8 beats x 8 bits and covers bypass and fixed positions.
// Instance b is 63 beats x 1 bit and covers random draws, backpressure,
// clipping of the error count and asynchronous reset.
module tb_err_injector;

    localparam int FL_A = 8;
    localparam int FL_B = 63;
    localparam int NF   = 100;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1;
    logic [1:0] cfg_mode_a = 2'b00;
    logic [1:0] cfg_num_err_a = 2'd0;
    logic [2:0] cfg_fixed_pos_a = 3'd0;
    logic       valid_in_a = 1'b0;
    logic       ready_in_a;
    logic [7:0] data_in_a = 8'h00;
    logic       valid_out_a;
    logic       ready_out_a = 1'b1;
    logic [7:0] data_out_a;
    logic       err_out_a, sof_out_a, eof_out_a, dbg_state_a;
    logic [15:0] err_total_a, frame_total_a;

    logic       rst_b = 1'b1;
    logic [1:0] cfg_mode_b = 2'b00;
    logic [1:0] cfg_num_err_b = 2'd0;
    logic [5:0] cfg_fixed_pos_b = 6'd0;
    logic       valid_in_b = 1'b0;
    logic       ready_in_b;
    logic [0:0] data_in_b = 1'b0;
    logic       valid_out_b;
    logic       ready_out_b = 1'b1;
    logic [0:0] data_out_b;
    logic       err_out_b, sof_out_b, eof_out_b, dbg_state_b;
    logic [15:0] err_total_b, frame_total_b;

    err_injector #(.DATA_W(8), .FRAME_LEN(FL_A), .MAX_ERR(2), .LFSR_SEED(32'hACE1_2468), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst_a), .cfg_mode(cfg_mode_a), .cfg_num_err(cfg_num_err_a),
        .cfg_fixed_pos(cfg_fixed_pos_a), .valid_in(valid_in_a), .ready_in(ready_in_a),
        .data_in(data_in_a), .valid_out(valid_out_a), .ready_out(ready_out_a),
        .data_out(data_out_a), .err_out(err_out_a), .sof_out(sof_out_a), .eof_out(eof_out_a),
        .err_total(err_total_a), .frame_total(frame_total_a), .dbg_state(dbg_state_a)
    );

    err_injector #(.DATA_W(1), .FRAME_LEN(FL_B), .MAX_ERR(2), .LFSR_SEED(32'hACE1_2468), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst_b), .cfg_mode(cfg_mode_b), .cfg_num_err(cfg_num_err_b),
        .cfg_fixed_pos(cfg_fixed_pos_b), .valid_in(valid_in_b), .ready_in(ready_in_b),
        .data_in(data_in_b), .valid_out(valid_out_b), .ready_out(ready_out_b),
        .data_out(data_out_b), .err_out(err_out_b), .sof_out(sof_out_b), .eof_out(eof_out_b),
        .err_total(err_total_b), .frame_total(frame_total_b), .dbg_state(dbg_state_b)
    );

    // scoreboard state
    int n_checks = 0;
    int n_errors = 0;
    int in_cnt_a = 0, out_cnt_a = 0, in_lim_a = 0;
    int in_cnt_b = 0, out_cnt_b = 0, in_lim_b = 0;
    bit pat_sel_a = 1'b0;
    bit bp_b = 1'b0;
    bit stall_b = 1'b0;
    logic [4:0] held_b = '0;
    int hold_bad_b = 0;
    logic [10:0] cap_a_q[$];
    logic [3:0]  cap_b_q[$];
    logic [3:0]  exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat_a(input int k);
        logic [7:0] v;
        v = 8'h5A ^ k[7:0];
        return pat_sel_a ? v : 8'h00;
    endfunction

    function automatic logic pat_b(input int k);
        return k[0] ^ k[2];
    endfunction

    // driver tasks
    task automatic drive_inputs();
        valid_in_a  = (in_cnt_a < in_lim_a);
        data_in_a   = pat_a(in_cnt_a);
        valid_in_b  = (in_cnt_b < in_lim_b);
        data_in_b   = pat_b(in_cnt_b);
        ready_out_a = 1'b1;
        ready_out_b = bp_b ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic step();
        bit fa, fb;
        @(negedge clk);
        if (stall_b && ({valid_out_b, sof_out_b, eof_out_b, err_out_b, data_out_b} != held_b))
            hold_bad_b++;
        stall_b = valid_out_b && !ready_out_b;
        held_b  = {valid_out_b, sof_out_b, eof_out_b, err_out_b, data_out_b};
        if (valid_out_a && ready_out_a) begin
            cap_a_q.push_back({sof_out_a, eof_out_a, err_out_a, data_out_a});
            out_cnt_a++;
        end
        if (valid_out_b && ready_out_b) begin
            cap_b_q.push_back({sof_out_b, eof_out_b, err_out_b, data_out_b});
            out_cnt_b++;
        end
        fa = valid_in_a && ready_in_a;
        fb = valid_in_b && ready_in_b;
        @(posedge clk);
        #1;
        if (fa) in_cnt_a++;
        if (fb) in_cnt_b++;
        drive_inputs();
    endtask

    task automatic wait_out_a(input int n, input int budget);
        int c = 0;
        while (out_cnt_a < n && c < budget) begin
            step();
            c++;
        end
        check_eq("timeout_a", out_cnt_a, n);
    endtask

    task automatic wait_out_b(input int n, input int budget);
        int c = 0;
        while (out_cnt_b < n && c < budget) begin
            step();
            c++;
        end
        check_eq("timeout_b", out_cnt_b, n);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        in_cnt_a = 0;
        out_cnt_a = 0;
        cap_a_q.delete();
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        in_cnt_b = 0;
        out_cnt_b = 0;
        stall_b = 1'b0;
        cap_b_q.delete();
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    // Fixed-mode frames on instance a against a hand-written per-beat flip mask.
    task automatic check_fixed_a(input string tag, input int nbeats, input logic [7:0] flip);
        int b;
        logic e;
        for (int k = 0; k < nbeats; k++) begin
            b = k % FL_A;
            e = flip[b];
            check_eq(tag, cap_a_q[k], {(b == 0), (b == FL_A - 1), e, pat_a(k) ^ {7'b0, e}});
        end
    endtask

    // One captured frame of instance b: flip count, framing, data, optional reference match.
    task automatic check_frame_b(input int f, input int exp_flips, input bit cmp_ref);
        int flips = 0, bad_fmt = 0, bad_ref = 0, k;
        logic [3:0] e;
        for (int b = 0; b < FL_B; b++) begin
            k = f * FL_B + b;
            e = (k < cap_b_q.size()) ? cap_b_q[k] : 4'b1111;
            if (e[1]) flips++;
            if (e[3] != (b == 0) || e[2] != (b == FL_B - 1) || e[0] != (pat_b(k) ^ e[1]))
                bad_fmt++;
            if (cmp_ref && (k >= exp_q.size() || e != exp_q[k])) bad_ref++;
        end
        check_eq("frame_flips", flips, exp_flips);
        check_eq("frame_format", bad_fmt, 0);
        if (cmp_ref) check_eq("frame_vs_ref", bad_ref, 0);
    endtask

    initial begin
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        // reset state, both instances held in reset
        check_eq("rst_valid_a", valid_out_a, 0);
        check_eq("rst_data_a", data_out_a, 0);
        check_eq("rst_flags_a", {err_out_a, sof_out_a, eof_out_a}, 0);
        check_eq("rst_cnt_a", {err_total_a, frame_total_a}, 0);
        check_eq("rst_ready_a", ready_in_a, 0);
        check_eq("rst_valid_b", valid_out_b, 0);
        check_eq("rst_cnt_b", {err_total_b, frame_total_b}, 0);
        check_eq("rst_state_b", dbg_state_b, 0);

        // 1: bypass, three frames of zeros
        cfg_mode_a = 2'b00;
        cfg_num_err_a = 2'd2;
        pat_sel_a = 1'b0;
        in_lim_a = 3 * FL_A;
        reset_a();
        wait_out_a(3 * FL_A, 200);
        check_fixed_a("t1_bypass", 3 * FL_A, 8'b0000_0000);
        check_eq("t1_err_total", err_total_a, 0);
        check_eq("t1_frame_total", frame_total_a, 3);

        // 2a: fixed, n=2 at beat 3 -> beats 3 and 4
        cfg_mode_a = 2'b11;
        cfg_num_err_a = 2'd2;
        cfg_fixed_pos_a = 3'd3;
        pat_sel_a = 1'b1;
        in_lim_a = 2 * FL_A;
        reset_a();
        wait_out_a(2 * FL_A, 200);
        check_fixed_a("t2_pos3", 2 * FL_A, 8'b0001_1000);
        check_eq("t2_pos3_err_total", err_total_a, 4);
        check_eq("t2_pos3_frame_total", frame_total_a, 2);

        // 2b: fixed at beat 7 -> burst truncated to the last beat only
        cfg_fixed_pos_a = 3'd7;
        reset_a();
        wait_out_a(2 * FL_A, 200);
        check_fixed_a("t2_pos7", 2 * FL_A, 8'b1000_0000);
        check_eq("t2_pos7_err_total", err_total_a, 2);
        in_lim_a = 0;

        // 3: random, n=2, reference run without backpressure
        cfg_mode_b = 2'b01;
        cfg_num_err_b = 2'd2;
        bp_b = 1'b0;
        in_lim_b = NF * FL_B;
        reset_b();
        wait_out_b(NF * FL_B, NF * FL_B * 2 + 1000);
        for (int f = 0; f < NF; f++) check_frame_b(f, 2, 1'b0);
        check_eq("t3_err_total", err_total_b, 2 * NF);
        check_eq("t3_frame_total", frame_total_b, NF);
        exp_q = cap_b_q;

        // 4: same config with random backpressure must reproduce the reference exactly
        bp_b = 1'b1;
        hold_bad_b = 0;
        reset_b();
        wait_out_b(NF * FL_B, NF * FL_B * 5 + 1000);
        for (int f = 0; f < NF; f++) check_frame_b(f, 2, 1'b1);
        check_eq("t4_err_total", err_total_b, 2 * NF);
        check_eq("t4_frame_total", frame_total_b, NF);
        check_eq("t4_hold", hold_bad_b, 0);
        repeat (20) step();
        check_eq("t4_no_extra", out_cnt_b, NF * FL_B);
        bp_b = 1'b0;

        // 5: n=3 clips to 2; mode change mid-frame applies from the next frame
        cfg_mode_b = 2'b01;
        cfg_num_err_b = 2'd3;
        in_lim_b = 3 * FL_B;
        reset_b();
        wait_out_b(30, 500);
        cfg_mode_b = 2'b00;
        cfg_num_err_b = 2'd0;
        wait_out_b(3 * FL_B, 1000);
        check_frame_b(0, 2, 1'b1);
        check_frame_b(1, 0, 1'b0);
        check_frame_b(2, 0, 1'b0);
        check_eq("t5_err_total", err_total_b, 2);
        check_eq("t5_frame_total", frame_total_b, 3);

        // 6: asynchronous reset at beat 20, then the reference pattern restarts
        cfg_mode_b = 2'b01;
        cfg_num_err_b = 2'd2;
        in_lim_b = 1000;
        reset_b();
        wait_out_b(20, 500);
        rst_b = 1'b1;
        #1;
        check_eq("t6_valid", valid_out_b, 0);
        check_eq("t6_data", data_out_b, 0);
        check_eq("t6_flags", {err_out_b, sof_out_b, eof_out_b}, 0);
        check_eq("t6_err_total", err_total_b, 0);
        check_eq("t6_frame_total", frame_total_b, 0);
        check_eq("t6_state", dbg_state_b, 0);
        in_lim_b = FL_B;
        reset_b();
        wait_out_b(FL_B, 500);
        check_eq("t6_sof", (cap_b_q.size() > 0) ? cap_b_q[0][3] : 1'b0, 1);
        check_frame_b(0, 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
